sub_result_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter directly downstream of the n-bit subtractor. It captures the subtractor's difference and carry-out and derives the sign from the carry-out (carry-out 0 means a < b). It converts the magnitude to packed BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock. Its output feeds the display and digit-mux logic.

---
 rtl/sub_bcd_pkg.sv | 25 ++
 rtl/bcd_digit_adjust.sv | 9 +
 rtl/sub_result_bcd_converter.sv | 98 +++++++++
 tb/tb_sub_result_bcd_converter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sub_bcd_pkg.sv
// Shared types and elaboration helpers for the subtractor-result BCD converter.
package sub_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of decimal digits needed to hold 2^n - 1.
    function automatic int min_digits(input int n);
        longint unsigned v;
        int d;
        v = (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adjust (
    input  logic [3:0] value,
    output logic [3:0] adjusted
);

    assign adjusted = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/sub_result_bcd_converter.sv
// Converts a subtractor difference/carry-out pair into sign plus packed BCD magnitude,
// one double-dabble iteration per clock.
module sub_result_bcd_converter
    import sub_bcd_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N-1:0]        diff,
    input  logic                cout,
    output logic                busy,
    output logic                done,
    output logic                neg,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int CW = $clog2(N + 1);
    localparam int BW = 4 * DIGITS;

    // Handshake: start is taken only while busy is low; busy stays high through
    // SHIFT and DONE; done pulses for one cycle with bcd/neg already valid.
    state_t          state;
    state_t          state_next;
    logic [N-1:0]    mag;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   scratch_adj;
    logic [CW-1:0]   count;
    logic            neg_r;

    generate
        if (DIGITS < min_digits(N)) begin : g_digits_check
            $error("DIGITS too small to hold 2^N-1");
        end
    endgenerate

    for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .value   (scratch[4*i +: 4]),
            .adjusted(scratch_adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            mag     <= '0;
            scratch <= '0;
            count   <= '0;
            neg_r   <= 1'b0;
            neg     <= 1'b0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Carry-out low means a < b: magnitude is the two's complement.
                        neg_r   <= ~cout;
                        mag     <= cout ? diff : (~diff + N'(1));
                        scratch <= '0;
                        count   <= CW'(N);
                    end
                end
                SHIFT: begin
                    {scratch, mag} <= {scratch_adj[BW-2:0], mag, 1'b0};
                    count          <= count - CW'(1);
                end
                DONE: begin
                    bcd  <= scratch;
                    neg  <= neg_r;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_result_bcd_converter.sv
// Self-checking bench for sub_result_bcd_converter against an arithmetic reference model.
module tb_sub_result_bcd_converter;

    localparam int N      = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;
    localparam int LAT    = N + 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  diff;
    logic          cout;
    logic          busy;
    logic          done;
    logic          neg;
    logic [BW-1:0] bcd;

    int tests;
    int failed;

    logic [BW:0] exp_q[$];

    sub_result_bcd_converter #(.N(N), .DIGITS(DIGITS)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .diff (diff),
        .cout (cout),
        .busy (busy),
        .done (done),
        .neg  (neg),
        .bcd  (bcd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: sign from carry-out, magnitude by modular arithmetic, digits by division.
    function automatic logic [BW:0] ref_model(input int d, input int c);
        int m;
        logic [BW-1:0] r;
        m = c ? d : ((1 << N) - d) % (1 << N);
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {(c == 0), r};
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; diff = '0; cout = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Launch one conversion, scramble inputs afterwards, check latency/busy/hold/result.
    task automatic run_conv(input logic [N-1:0] d, input logic c, input string tag);
        logic [BW-1:0] prev_bcd;
        logic          prev_neg;
        logic [BW:0]   exp;
        int            edges;
        int            busy_cycles;
        bit            held;
        prev_bcd = bcd;
        prev_neg = neg;
        held     = 1'b1;
        exp_q.push_back(ref_model(int'(d), int'(c)));
        @(negedge clk);
        diff = d; cout = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        diff  = N'($urandom_range(0, 255));
        cout  = 1'($urandom_range(0, 1));
        edges = 1;
        busy_cycles = 0;
        while (!done && edges < LAT + 8) begin
            if (busy) busy_cycles++;
            if (bcd !== prev_bcd || neg !== prev_neg) held = 1'b0;
            @(negedge clk);
            edges++;
        end
        exp = exp_q.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'(LAT));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(N + 1));
        check({tag, "_hold"}, 32'(held), 32'd1);
        check({tag, "_bcd"}, 32'(bcd), 32'(exp[BW-1:0]));
        check({tag, "_neg"}, 32'(neg), 32'(exp[BW]));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dones;
        tests  = 0;
        failed = 0;
        do_reset();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_neg", 32'(neg), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);

        run_conv(8'h1E, 1'b1, "d1e");
        check("d1e_lit", 32'(bcd), 32'h030);
        run_conv(8'hF6, 1'b0, "df6");
        check("df6_lit", 32'({neg, bcd}), 32'h1010);
        run_conv(8'hFF, 1'b1, "dff");
        check("dff_lit", 32'({neg, bcd}), 32'h0255);
        run_conv(8'h01, 1'b0, "d01n");
        check("d01n_lit", 32'({neg, bcd}), 32'h1255);
        run_conv(8'h00, 1'b1, "d00");
        check("d00_lit", 32'({neg, bcd}), 32'h0000);
        run_conv(8'h00, 1'b0, "d00n");

        // Start while busy must be ignored.
        @(negedge clk);
        diff = 8'h07; cout = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 1; i < 2 * LAT + 4; i++) begin
            if (i == 3) begin
                diff = 8'h09; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) dones++;
            @(negedge clk);
        end
        check("ignore_dones", 32'(dones), 32'd1);
        check("ignore_bcd", 32'({neg, bcd}), 32'h0007);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        diff = 8'h63; cout = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        dones = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_dones", 32'(dones), 32'd0);
        run_conv(8'h2A, 1'b1, "d2a");
        check("d2a_lit", 32'(bcd), 32'h042);

        // Start held high: back-to-back conversions every N+2 cycles.
        @(negedge clk);
        diff = 8'h80; cout = 1'b1; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        check("held_start_dones", 32'(dones), 32'd3);
        check("held_start_bcd", 32'(bcd), 32'h128);
        repeat (LAT + 2) @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            run_conv(N'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
